// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings and widths for the MEM->WB pipeline register.
package mem_wb_stage_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_RAM = 2'd1,
        WB_SEL_PC4 = 2'd2,
        WB_SEL_IMM = 2'd3
    } wb_sel_e;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-side slot and WB-side results exchanged with the MEM->WB register.
interface mem_wb_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  validIn;
    logic [1:0]            select;
    logic [2:0]            loadFunct3;
    logic [1:0]            byteOffset;
    logic [DATA_W-1:0]     dataFromALU;
    logic [DATA_W-1:0]     dataFromRam;
    logic [DATA_W-1:0]     pcPlus4;
    logic [DATA_W-1:0]     immData;
    logic                  regWriteEnableIn;
    logic [REG_ADDR_W-1:0] writeBackAddrIn;

    logic                  validOut;
    logic                  regWriteEnableOut;
    logic [REG_ADDR_W-1:0] writeBackAddrOut;
    logic [DATA_W-1:0]     dataToReg;
    logic [CNT_W-1:0]      retireCount;

    modport master (
        output validIn, select, loadFunct3, byteOffset,
        output dataFromALU, dataFromRam, pcPlus4, immData,
        output regWriteEnableIn, writeBackAddrIn,
        input  validOut, regWriteEnableOut, writeBackAddrOut,
        input  dataToReg, retireCount
    );

    modport slave (
        input  validIn, select, loadFunct3, byteOffset,
        input  dataFromALU, dataFromRam, pcPlus4, immData,
        input  regWriteEnableIn, writeBackAddrIn,
        output validOut, regWriteEnableOut, writeBackAddrOut,
        output dataToReg, retireCount
    );
endinterface

// File: rtl/mem_wb_stage_load_formatter.sv
// Combinational byte/half extraction with sign or zero extension.
module mem_wb_stage_load_formatter
    import mem_wb_stage_pkg::*;
(
    input  logic [XLEN-1:0] dataFromRam,
    input  logic [2:0]      loadFunct3,
    input  logic [1:0]      byteOffset,
    output logic [XLEN-1:0] dataOut
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Halfword lane ignores byteOffset[0]; misalignment is not trapped here.
    assign byte_lane = dataFromRam[8*byteOffset +: 8];
    assign half_lane = dataFromRam[16*byteOffset[1] +: 16];

    always_comb begin
        dataOut = dataFromRam;
        unique case (loadFunct3)
            LOAD_LB:  dataOut = {{24{byte_lane[7]}}, byte_lane};
            LOAD_LH:  dataOut = {{16{half_lane[15]}}, half_lane};
            LOAD_LBU: dataOut = {24'd0, byte_lane};
            LOAD_LHU: dataOut = {16'd0, half_lane};
            LOAD_LW:  dataOut = dataFromRam;
            default:  dataOut = dataFromRam;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: writeback mux, stall/flush, x0 guard and
// retired-instruction counter.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W     = XLEN,
    parameter int REG_ADDR_W = REG_AW,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    mem_wb_stage_if.slave      bus
);

    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] wb_data;
    logic              we_next;

    mem_wb_stage_load_formatter u_fmt (
        .dataFromRam (bus.dataFromRam),
        .loadFunct3  (bus.loadFunct3),
        .byteOffset  (bus.byteOffset),
        .dataOut     (load_data)
    );

    always_comb begin
        wb_data = bus.dataFromALU;
        unique case (wb_sel_e'(bus.select))
            WB_SEL_ALU: wb_data = bus.dataFromALU;
            WB_SEL_RAM: wb_data = load_data;
            WB_SEL_PC4: wb_data = bus.pcPlus4;
            WB_SEL_IMM: wb_data = bus.immData;
            default:    wb_data = bus.dataFromALU;
        endcase
    end

    assign we_next = bus.regWriteEnableIn & bus.validIn
                   & (bus.writeBackAddrIn != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.validOut          <= 1'b0;
            bus.regWriteEnableOut <= 1'b0;
            bus.writeBackAddrOut  <= '0;
            bus.dataToReg         <= '0;
            bus.retireCount       <= '0;
        end else if (flush) begin
            bus.validOut          <= 1'b0;
            bus.regWriteEnableOut <= 1'b0;
            bus.writeBackAddrOut  <= '0;
            bus.dataToReg         <= '0;
        end else if (!stall) begin
            bus.validOut          <= bus.validIn;
            bus.regWriteEnableOut <= we_next;
            bus.writeBackAddrOut  <= bus.writeBackAddrIn;
            bus.dataToReg         <= wb_data;
            if (bus.validIn)
                bus.retireCount <= bus.retireCount + CNT_W'(1);
        end
    end

endmodule
